pipe_skid_chain: RTL
====================

// Module: pipe_skid_chain
// PURPOSE
//   Parametrised elastic pipeline register for the ARM core. It generalises the fixed
//   ID/EXE latch into STAGES chained slices carrying a DATA_W payload.
//   Each slice has a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
//   Lets the stage boundaries (ID/EXE, EXE/MEM, ...) absorb back-pressure without losing
//   instructions and sustain full throughput.
// PARAMETERS
//   DATA_W      64  payload width in bits (packed control + operand fields)
//   STAGES      1   number of chained slices; 1..8
//   CLEAR_DATA  1   1: payload registers zeroed on flush; 0: payload held, only valids cleared
// PORTS
//   clk        in   1                         clock, rising edge
//   rst        in   1                         asynchronous, active-high reset
//   flush      in   1                         synchronous kill of all in-flight entries
//   up_valid   in   1                         upstream offers up_data
//   up_ready   out  1                         chain accepts up_data this cycle
//   up_data    in   DATA_W                    payload in
//   dn_valid   out  1                         dn_data valid
//   dn_ready   in   1                         downstream consumes dn_data this cycle
//   dn_data    out  DATA_W                    payload out
//   occupancy  out  $clog2(2*STAGES+1)        live entries across all slices
// BEHAVIOUR
//   - Reset (async): every main/skid valid = 0; payloads = 0; dn_valid = 0, dn_data = 0,
//     occupancy = 0, up_ready = 1 once rst deasserts.
//   - Transfer rule: a beat moves only when valid && ready are both high at the rising edge.
//   - Slice state: {main_v, skid_v}, with legal states EMPTY(0,0), ONE(1,0), FULL(1,1).
//     - slice up_ready = !skid_v (registered, no combinational path from dn_ready).
//     - slice dn_valid = main_v; dn_data = main payload.
//   - Transitions per slice (in = upstream beat accepted, out = downstream beat taken):
//     - EMPTY, in          -> ONE   (main <= in)
//     - ONE, in & out      -> ONE   (main <= in)
//     - ONE, in & !out     -> FULL  (skid <= in)
//     - ONE, !in & out     -> EMPTY
//     - FULL, out          -> ONE   (main <= skid; no in possible, up_ready = 0)
//     - otherwise          -> hold
//   - Latency: 1 cycle per slice, STAGES cycles total when dn_ready is held high.
//     Throughput is 1 beat/cycle in steady state.
//   - Ordering: strict FIFO order; no beat is duplicated or dropped except by flush.
//   - Flush: highest synchronous priority.
//     - Next edge clears all valids in all slices.
//     - An up handshake in the flush cycle is discarded.
//     - A dn handshake in the flush cycle still counts as consumed by the downstream.
//     - Payload is zeroed iff CLEAR_DATA = 1.
//     - up_ready = 1 in the cycle after flush.
//   - Flush held several cycles: chain stays EMPTY; up_ready stays 1; nothing is accepted.
//   - occupancy = sum over slices of main_v + skid_v; registered; max value 2*STAGES.
//   - rst asserted mid-transfer: immediate clear; the in-flight beat is lost by design.
//   - dn_ready is low at reset/empty: dn_valid = 0; no X on dn_data.
// STRUCTURE
//   - Shared package/defines file: PIPE_MAX_STAGES = 8, slice state encodings
//     (EMPTY/ONE/FULL) for bench assertions.
//   - Sub-module pipe_skid_slice holds one slice: ports clk, rst, flush, up_*, dn_*,
//     and a 2-bit cnt.
//   - Top instantiates STAGES slices with generate; the occupancy adder is in the top.
// TESTING
//   1. Reset, STAGES=1: rst=1 mid-run -> dn_valid=0, occupancy=0, dn_data=0;
//      after release up_ready=1.
//   2. Streaming, STAGES=3, dn_ready=1: send 0x1..0x10 back-to-back -> 0x1 appears on
//      cycle 3; all 16 arrive in consecutive cycles, in order.
//   3. Back-pressure, STAGES=1: send A,B,C with dn_ready=0 -> A in main, B in skid,
//      up_ready=0 and C held.
//      Then dn_ready=1 -> A, B, C delivered in order; occupancy 2->1->1->0.
//   4. Full chain, STAGES=2: dn_ready=0, offer 6 beats -> 4 accepted, occupancy=4,
//      up_ready=0.
//      Release -> exactly those 4 beats out in order, none lost.
//   5. Flush, STAGES=2, CLEAR_DATA=1: 3 beats in flight, flush together with
//      up_valid=1 data 0xDEAD -> next cycle occupancy=0, dn_valid=0, payloads 0;
//      0xDEAD never appears.
//   6. Random valid/ready, 10k cycles, both CLEAR_DATA values -> scoreboard: order
//      preserved, no duplicates, occupancy equals the model every cycle.

Source files
------------

// File: rtl/pipe_skid_chain_pkg.sv
// rtl/pipe_skid_chain_pkg.sv - shared constants and slice state encodings for the skid chain
package pipe_skid_chain_pkg;

  localparam int PIPE_MAX_STAGES = 8;

  // Encoding is {main_v, skid_v}, so the state bits double as the valid flags.
  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'b00,
    SLICE_ONE   = 2'b10,
    SLICE_FULL  = 2'b11
  } slice_state_e;

endpackage

// File: rtl/pipe_skid_slice.sv
// rtl/pipe_skid_slice.sv - one elastic slice: main register plus one-entry skid, registered ready
module pipe_skid_slice
  import pipe_skid_chain_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        cnt
);

  slice_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_hs;
  logic              out_hs;

  // Ready depends only on the skid flag, so back-pressure never ripples combinationally.
  assign up_ready = (state_q != SLICE_FULL);
  assign dn_valid = (state_q != SLICE_EMPTY);
  assign dn_data  = main_q;
  assign cnt      = {1'b0, dn_valid} + {1'b0, ~up_ready};

  assign in_hs  = up_valid & up_ready;
  assign out_hs = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SLICE_EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        SLICE_EMPTY: begin
          if (in_hs) begin
            state_d = SLICE_ONE;
            main_d  = up_data;
          end
        end
        SLICE_ONE: begin
          if (in_hs && out_hs) begin
            main_d = up_data;
          end else if (in_hs) begin
            state_d = SLICE_FULL;
            skid_d  = up_data;
          end else if (out_hs) begin
            state_d = SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          if (out_hs) begin
            state_d = SLICE_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = SLICE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLICE_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_skid_chain.sv
// rtl/pipe_skid_chain.sv - STAGES chained skid slices with a live-entry occupancy count
module pipe_skid_chain
  import pipe_skid_chain_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int STAGES     = 1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             up_valid,
  output logic                             up_ready,
  input  logic [DATA_W-1:0]                up_data,
  output logic                             dn_valid,
  input  logic                             dn_ready,
  output logic [DATA_W-1:0]                dn_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  // Index i is the boundary feeding slice i; index STAGES is the chain output.
  logic              v_chain [STAGES+1];
  logic              r_chain [STAGES+1];
  logic [DATA_W-1:0] d_chain [STAGES+1];
  logic [1:0]        cnt     [STAGES];
  logic [OCC_W-1:0]  occ_sum;

  assign v_chain[0]      = up_valid;
  assign d_chain[0]      = up_data;
  assign up_ready        = r_chain[0];
  assign r_chain[STAGES] = dn_ready;
  assign dn_valid        = v_chain[STAGES];
  assign dn_data         = d_chain[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    pipe_skid_slice #(
      .DATA_W     (DATA_W),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (v_chain[i]),
      .up_ready (r_chain[i]),
      .up_data  (d_chain[i]),
      .dn_valid (v_chain[i+1]),
      .dn_ready (r_chain[i+1]),
      .dn_data  (d_chain[i+1]),
      .cnt      (cnt[i])
    );
  end

  // Sum of per-slice counts; every term comes straight from slice state registers.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(cnt[i]);
    end
  end

  assign occupancy = occ_sum;

endmodule
